flit_output_scheduler: RTL and testbench

- Per-output-port scheduler for the router crossbar.
- Shares one output link between four input ports using round-robin arbitration with wormhole packet locking. Once a head flit wins, the port keeps the link until its tail flit passes.
- Drives the crossbar mux select and per-port stall signals.
- Gates every transfer on a downstream credit counter so the next-hop input buffer can never overflow.

---
 rtl/flit_output_scheduler.sv | 143 ++++++++++++++
 tb/tb_flit_output_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/flit_output_scheduler.sv
// Output-port scheduler for the router crossbar.
// Four input ports share one output link under round-robin arbitration with
// wormhole locking: a winning head flit holds the link until its tail passes.
// Every transfer is gated on a downstream credit counter.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no packet owns the link; head flits arbitrate round-robin
// LOCKED | owner is mid-packet; only owner may send until its tail flit
module flit_output_scheduler #(
    parameter int unsigned CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] head,
    input  logic [3:0] tail,
    input  logic       credit_return,
    output logic [3:0] grant,
    output logic [1:0] mux_select,
    output logic       out_valid,
    output logic [3:0] port_block,
    output logic       err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

    state_t     fsm;
    logic [1:0] owner;
    logic [1:0] rr_ptr;
    logic [3:0] credit_cnt;

    logic [3:0] eligible;
    logic       credit_ok;
    logic       win_found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       grant_vld;
    logic [1:0] grant_sel;
    logic       err_set;

    assign eligible  = req & head;
    // Reset also blocks grants so outputs are quiet the instant rst_n falls.
    assign credit_ok = (credit_cnt != 4'd0) && rst_n;

    // Round-robin search over head flits, starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        winner    = rr_ptr;
        idx       = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    // Pick the port that crosses the link this cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 2'd0;
        if (credit_ok) begin
            if (fsm == IDLE) begin
                if (win_found) begin
                    grant_vld = 1'b1;
                    grant_sel = winner;
                end
            end else if (req[owner]) begin
                grant_vld = 1'b1;
                grant_sel = owner;
            end
        end
    end

    assign grant      = grant_vld ? (4'b0001 << grant_sel) : 4'b0000;
    assign mux_select = grant_vld ? grant_sel : 2'd0;
    assign out_valid  = grant_vld;
    assign port_block = req & ~grant;

    // A head flit from the owner mid-packet, or a credit returned into a
    // full counter, is a protocol violation.
    assign err_set = ((fsm == LOCKED) && grant_vld && head[owner]) ||
                     (credit_return && !grant_vld && (credit_cnt == CREDIT_MAX));

    // Packet lock and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm    <= IDLE;
            owner  <= 2'd0;
            rr_ptr <= 2'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (grant_vld) begin
                        if (tail[grant_sel]) begin
                            rr_ptr <= grant_sel + 2'd1;
                        end else begin
                            fsm   <= LOCKED;
                            owner <= grant_sel;
                        end
                    end
                end
                LOCKED: begin
                    if (grant_vld && tail[owner]) begin
                        fsm    <= IDLE;
                        rr_ptr <= owner + 2'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Downstream credits: one per send, one back per return, capped at CREDITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_MAX;
        end else begin
            if (grant_vld && !credit_return) begin
                credit_cnt <= credit_cnt - 4'd1;
            end else if (!grant_vld && credit_return && (credit_cnt != CREDIT_MAX)) begin
                credit_cnt <= credit_cnt + 4'd1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flit_output_scheduler.sv
// Self-checking bench for flit_output_scheduler: directed scenarios followed
// by random traffic, all compared against a packet-level reference model.
module tb_flit_output_scheduler;

    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] head = '0;
    logic [3:0] tail = '0;
    logic       credit_return = 1'b0;
    logic [3:0] grant;
    logic [1:0] mux_select;
    logic       out_valid;
    logic [3:0] port_block;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_cred;
    bit m_err;

    flit_output_scheduler #(.CREDITS(CREDITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .head          (head),
        .tail          (tail),
        .credit_return (credit_return),
        .grant         (grant),
        .mux_select    (mux_select),
        .out_valid     (out_valid),
        .port_block    (port_block),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cred   = CREDITS;
        m_err    = 0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] h,
                        input logic [3:0] t, input logic cr);
        int         win;
        logic [3:0] exp_grant;
        @(negedge clk);
        req = r; head = h; tail = t; credit_return = cr;
        #1;
        win = -1;
        if (m_cred > 0) begin
            if (!m_locked) begin
                for (int k = 0; k < 4; k++) begin
                    int p;
                    p = (m_ptr + k) % 4;
                    if (win < 0 && r[p] && h[p]) win = p;
                end
            end else if (r[m_owner]) begin
                win = m_owner;
            end
        end
        exp_grant = (win < 0) ? 4'b0000 : 4'(1 << win);
        check({tag, ".grant"}, grant, exp_grant);
        check({tag, ".mux_select"}, {2'b00, mux_select}, (win < 0) ? 4'd0 : 4'(win));
        check({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, (win >= 0)});
        check({tag, ".port_block"}, port_block, r & ~exp_grant);
        check({tag, ".err"}, {3'b000, err}, {3'b000, m_err});
        @(posedge clk);
        if (win >= 0) begin
            if (m_locked && h[win]) m_err = 1;
            if (t[win]) begin
                m_locked = 0;
                m_ptr    = (win + 1) % 4;
            end else begin
                m_locked = 1;
                m_owner  = win;
            end
            if (!cr) m_cred--;
        end else if (cr) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must go quiet immediately.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_grant"}, grant, 4'b0000);
        check({tag, ".rst_mux"}, {2'b00, mux_select}, 4'd0);
        check({tag, ".rst_valid"}, {3'b000, out_valid}, 4'd0);
        check({tag, ".rst_block"}, port_block, req);
        check({tag, ".rst_err"}, {3'b000, err}, 4'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        req = 4'hF; head = 4'hF; tail = 4'hF;
        do_reset("init");

        // All ports sending single-flit packets: round-robin until credits run out.
        for (int i = 0; i < 6; i++) step("rr_all", 4'hF, 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) step("refill", 4'h0, 4'h0, 4'h0, 1'b1);
        step("rr_after_refill", 4'hF, 4'hF, 4'hF, 1'b0);

        // Port 2 three-flit packet while port 0 keeps presenting a head.
        do_reset("pkt");
        step("pkt_p1", 4'b0010, 4'b0010, 4'b0010, 1'b0);
        step("pkt_head", 4'b0101, 4'b0101, 4'b0001, 1'b1);
        step("pkt_body", 4'b0101, 4'b0001, 4'b0001, 1'b1);
        step("pkt_tail", 4'b0101, 4'b0001, 4'b0101, 1'b1);
        step("pkt_next", 4'b0101, 4'b0101, 4'b0101, 1'b1);
        step("pkt_after", 4'b0101, 4'b0101, 4'b0101, 1'b0);

        // Last credit: send and return in the same cycle keeps it.
        do_reset("cred");
        for (int i = 0; i < 3; i++) step("cred_drain", 4'b0001, 4'b0001, 4'b0001, 1'b0);
        step("cred_same", 4'b0001, 4'b0001, 4'b0001, 1'b1);
        step("cred_last", 4'b0001, 4'b0001, 4'b0001, 1'b0);
        step("cred_empty", 4'b0001, 4'b0001, 4'b0001, 1'b0);
        step("cred_return", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        step("cred_usable", 4'b0001, 4'b0001, 4'b0001, 1'b0);

        // Credit return into a full counter.
        do_reset("ovf");
        step("ovf_pulse", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        step("ovf_sticky", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step("ovf_still_full", 4'hF, 4'hF, 4'hF, 1'b0);

        // Owner presents a head mid-packet, then a bubble, then its tail.
        do_reset("dup");
        step("dup_lock", 4'b0010, 4'b0010, 4'b0000, 1'b0);
        step("dup_head", 4'b0010, 4'b0010, 4'b0000, 1'b0);
        step("dup_bubble", 4'b0001, 4'b0001, 4'b0001, 1'b0);
        step("dup_tail", 4'b0011, 4'b0001, 4'b0011, 1'b0);

        // Reset mid-packet drops the lock; the orphan body flit is not eligible.
        do_reset("mid");
        step("mid_head", 4'b1000, 4'b1000, 4'b0000, 1'b0);
        step("mid_body", 4'b1000, 4'b0000, 4'b0000, 1'b0);
        do_reset("mid_rst");
        step("mid_after", 4'b1010, 4'b0010, 4'b0000, 1'b0);

        // Random traffic with occasional resets.
        do_reset("rnd");
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r, h, t;
            r = 4'($urandom);
            h = 4'($urandom) & 4'($urandom);
            t = 4'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
            step("rnd", r, h, t, 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
